wb_port_arbiter: RTL and testbench



---
 rtl/wb_arb_pkg.sv | 18 +
 rtl/wb_hold_buf.sv | 37 +++
 rtl/wb_port_arbiter.sv | 120 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_arb_pkg;
    localparam int       WB_XLEN           = 32;
    localparam int       DEF_STARVE_LIMIT  = 4;
    localparam logic [4:0] REG_ZERO        = 5'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        FORCE = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic               we;
        logic [4:0]         rd;
        logic [WB_XLEN-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/wb_hold_buf.sv
// One-entry MDU result buffer: loads on a valid/ready handshake, empties on drain or drop.
module wb_hold_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_data,
    input  logic            clear,
    input  logic            drop,
    output logic [4:0]      buf_rd,
    output logic [XLEN-1:0] buf_data
);
    logic valid_q;
    logic load;

    assign in_ready = !valid_q;
    assign load     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            buf_rd   <= '0;
            buf_data <= '0;
        end else begin
            if (load) begin
                valid_q  <= 1'b1;
                buf_rd   <= in_rd;
                buf_data <= in_data;
            end else if (clear || drop) begin
                valid_q  <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, MDU result waits in a
// one-entry buffer with a starvation-forced grant. WB_WAW_DROP_EN enables dropping a buffered
// result overwritten by a younger pipeline write to the same register.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int XLEN         = WB_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_wr_en,
    input  logic [4:0]      pipe_rd,
    input  logic [XLEN-1:0] pipe_wdata,
    input  logic            mdu_valid,
    input  logic [4:0]      mdu_rd,
    input  logic [XLEN-1:0] mdu_wdata,
    output logic            mdu_ready,
    output logic            pipe_stall,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_HELD  = HELD;
    localparam logic [1:0] ST_FORCE = FORCE;

    logic [1:0]      state, state_nxt;
    logic [3:0]      starve_cnt, cnt_nxt;
    logic            pipe_real, sel_pipe, sel_buf, drop;
    logic            buf_in_ready;
    logic [4:0]      buf_rd;
    logic [XLEN-1:0] buf_data;

    assign pipe_real  = pipe_wr_en && (pipe_rd != REG_ZERO);
    assign mdu_ready  = (state == ST_IDLE) && buf_in_ready;
    assign pipe_stall = (state == ST_FORCE) && pipe_wr_en;

    wb_hold_buf #(.XLEN(XLEN)) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (mdu_valid),
        .in_ready (buf_in_ready),
        .in_rd    (mdu_rd),
        .in_data  (mdu_wdata),
        .clear    (sel_buf),
        .drop     (drop),
        .buf_rd   (buf_rd),
        .buf_data (buf_data)
    );

    always_comb begin
        sel_pipe  = 1'b0;
        sel_buf   = 1'b0;
        drop      = 1'b0;
        state_nxt = state;
        cnt_nxt   = starve_cnt;
        case (state)
            ST_IDLE: begin
                sel_pipe = pipe_real;
                if (mdu_valid && mdu_ready) begin
                    state_nxt = ST_HELD;
                    cnt_nxt   = '0;
                end
            end
            ST_HELD: begin
                // A non-real pipe slot (idle or x0 write) is a free slot for the buffer.
                if (!pipe_real) begin
                    sel_buf   = 1'b1;
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
`ifdef WB_WAW_DROP_EN
                else if (pipe_rd == buf_rd) begin
                    sel_pipe  = 1'b1;
                    drop      = 1'b1;
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
`endif
                else begin
                    sel_pipe = 1'b1;
                    cnt_nxt  = starve_cnt + 4'd1;
                    if (cnt_nxt == 4'(STARVE_LIMIT))
                        state_nxt = ST_FORCE;
                end
            end
            ST_FORCE: begin
                sel_buf   = 1'b1;
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            starve_cnt <= '0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= cnt_nxt;
            rf_we      <= sel_buf ? (buf_rd != REG_ZERO) : sel_pipe;
            if (sel_buf) begin
                rf_waddr <= buf_rd;
                rf_wdata <= buf_data;
            end else if (sel_pipe) begin
                rf_waddr <= pipe_rd;
                rf_wdata <= pipe_wdata;
            end
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (default STARVE_LIMIT=4); WAW-drop case only with WB_WAW_DROP_EN.
module tb_wb_port_arbiter;
    import wb_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_wr_en = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [31:0] pipe_wdata = '0;
    logic        mdu_valid = 1'b0;
    logic [4:0]  mdu_rd = '0;
    logic [31:0] mdu_wdata = '0;
    logic        mdu_ready, pipe_stall, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_chk = 0;
    int n_bad = 0;

    wb_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_wr_en(pipe_wr_en), .pipe_rd(pipe_rd), .pipe_wdata(pipe_wdata),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_wdata(mdu_wdata),
        .mdu_ready(mdu_ready), .pipe_stall(pipe_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

`ifndef WB_WAW_DROP_EN
    // Without the drop logic the hazard unit must never present a same-register write while HELD.
    always @(posedge clk)
        if (rst_n)
            assert (!(dut.state == HELD && pipe_wr_en && pipe_rd != REG_ZERO && pipe_rd == dut.buf_rd))
            else $error("FAIL waw_hazard rd=%0d", pipe_rd);
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input wb_req_t e);
        chk({tag, ".we"}, 64'(rf_we), 64'(e.we));
        if (e.we) begin
            chk({tag, ".addr"}, 64'(rf_waddr), 64'(e.rd));
            chk({tag, ".data"}, 64'(rf_wdata), 64'(e.data));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic en, input logic [4:0] rd, input logic [31:0] d);
        pipe_wr_en = en; pipe_rd = rd; pipe_wdata = d;
    endtask

    task automatic mdu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        mdu_valid = v; mdu_rd = rd; mdu_wdata = d;
    endtask

    initial begin
        // reset and first pipe write
        tick(); tick();
        rst_n = 1'b1;
        chk("rst.we", 64'(rf_we), 64'd0);
        chk("rst.ready", 64'(mdu_ready), 64'd1);
        pipe(1, 5'd5, 32'h11);
        tick();
        chk_wr("pipe_x5", '{we: 1'b1, rd: 5'd5, data: 32'h11});

        // load buffer alongside a pipe write, then reset mid-cycle
        pipe(1, 5'd10, 32'hAA);
        mdu(1, 5'd2, 32'h22);
        tick();
        pipe(0, 0, 0); mdu(0, 0, 0);
        chk_wr("pipe_x10", '{we: 1'b1, rd: 5'd10, data: 32'hAA});
        chk("held.ready", 64'(mdu_ready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async.we", 64'(rf_we), 64'd0);
        chk("async.addr", 64'(rf_waddr), 64'd0);
        chk("async.ready", 64'(mdu_ready), 64'd1);
        chk("async.stall", 64'(pipe_stall), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("discard.we0", 64'(rf_we), 64'd0);
        tick();
        chk("discard.we1", 64'(rf_we), 64'd0);

        // idle drain
        mdu(1, 5'd7, 32'hDEAD);
        #1 chk("drain.ready0", 64'(mdu_ready), 64'd1);
        tick();
        mdu(0, 0, 0);
        chk("drain.t1we", 64'(rf_we), 64'd0);
        chk("drain.t1ready", 64'(mdu_ready), 64'd0);
        tick();
        chk_wr("drain.t2", '{we: 1'b1, rd: 5'd7, data: 32'hDEAD});
        chk("drain.t2ready", 64'(mdu_ready), 64'd1);

        // starvation: four pipe writes, then a forced MDU grant
        mdu(1, 5'd9, 32'hBEEF);
        tick();
        mdu(0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            pipe(1, 5'(i), 32'h100 + 32'(i));
            #1 chk($sformatf("starve.stall%0d", i), 64'(pipe_stall), 64'd0);
            tick();
            chk_wr($sformatf("starve.x%0d", i), '{we: 1'b1, rd: 5'(i), data: 32'h100 + 32'(i)});
        end
        pipe(1, 5'd6, 32'h66);
        #1 chk("force.stall", 64'(pipe_stall), 64'd1);
        chk("force.ready", 64'(mdu_ready), 64'd0);
        tick();
        chk_wr("force.x9", '{we: 1'b1, rd: 5'd9, data: 32'hBEEF});
        #1 chk("after_force.stall", 64'(pipe_stall), 64'd0);
        tick();
        pipe(0, 0, 0);
        chk_wr("after_force.x6", '{we: 1'b1, rd: 5'd6, data: 32'h66});

        // x0 writes: dropped in IDLE, free slot in HELD
        pipe(1, 5'd0, 32'hFFFF);
        tick();
        chk("x0.idle_we", 64'(rf_we), 64'd0);
        pipe(0, 0, 0);
        mdu(1, 5'd12, 32'hC0DE);
        tick();
        mdu(0, 0, 0);
        pipe(1, 5'd0, 32'hFFFF);
        #1 chk("x0.stall", 64'(pipe_stall), 64'd0);
        tick();
        pipe(0, 0, 0);
        chk_wr("x0.drain", '{we: 1'b1, rd: 5'd12, data: 32'hC0DE});
        chk("x0.ready", 64'(mdu_ready), 64'd1);

        // buffered rd==0 frees the buffer without a write
        mdu(1, 5'd0, 32'h77);
        tick();
        mdu(0, 0, 0);
        tick();
        chk("mdu_x0.we", 64'(rf_we), 64'd0);
        chk("mdu_x0.ready", 64'(mdu_ready), 64'd1);

`ifdef WB_WAW_DROP_EN
        // younger pipe write to the same register drops the buffered result
        mdu(1, 5'd3, 32'h1);
        tick();
        mdu(0, 0, 0);
        pipe(1, 5'd3, 32'h2);
        tick();
        pipe(0, 0, 0);
        chk_wr("waw.pipe", '{we: 1'b1, rd: 5'd3, data: 32'h2});
        chk("waw.ready", 64'(mdu_ready), 64'd1);
        tick();
        chk("waw.nodrain", 64'(rf_we), 64'd0);
`endif

        // backpressure: second MDU result waits for the first to drain
        mdu(1, 5'd4, 32'h44);
        tick();
        mdu(1, 5'd8, 32'h55);
        #1 chk("bp.ready0", 64'(mdu_ready), 64'd0);
        tick();
        chk_wr("bp.x4", '{we: 1'b1, rd: 5'd4, data: 32'h44});
        chk("bp.ready1", 64'(mdu_ready), 64'd1);
        tick();
        mdu(0, 0, 0);
        chk("bp.gap", 64'(rf_we), 64'd0);
        tick();
        chk_wr("bp.x8", '{we: 1'b1, rd: 5'd8, data: 32'h55});

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
